// File: rtl/mlp_result_writer.sv
// Result-side engine of the MNIST MLP: tracks the per-image argmax of the score stream,
// buffers results in a small FIFO and writes them to y_buf at byte addresses from a base.
module mlp_result_writer #(
  parameter int NUM_IMG        = 10,
  parameter int NUM_CLASS      = 10,
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int BYTES_PER_WORD = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         mode_i,
  input  logic [ADDR_W-1:0]            base_addr_i,
  input  logic                         score_valid_i,
  output logic                         score_ready_o,
  input  logic [DATA_W-1:0]            score_data_i,
  input  logic                         y_buf_stall_i,
  output logic                         y_buf_en_o,
  output logic                         y_buf_wr_en_o,
  output logic [ADDR_W-1:0]            y_buf_addr_o,
  output logic [DATA_W-1:0]            y_buf_data_o,
  output logic                         pred_valid_o,
  output logic [$clog2(NUM_IMG)-1:0]   pred_img_o,
  output logic [$clog2(NUM_CLASS)-1:0] pred_class_o,
  output logic                         done_intr_o,
  output logic                         done_led_o
);

  localparam int IMG_W = $clog2(NUM_IMG);
  localparam int CLS_W = $clog2(NUM_CLASS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state_q, state_d;

  logic [CLS_W-1:0]         class_cnt_q;
  logic [IMG_W-1:0]         img_cnt_q;
  logic                     mode_q;
  logic [ADDR_W-1:0]        wr_addr_q;
  logic signed [DATA_W-1:0] max_q, max_d;
  logic [CLS_W-1:0]         idx_q, idx_d;

  logic [DATA_W-1:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]         fifo_cnt_q;
  logic                     fifo_full, fifo_empty;

  logic                     strobe_q;
  logic                     done_led_q;

  logic                     start_go;
  logic                     accept;
  logic                     last_class, last_img;
  logic                     push, pop;
  logic [DATA_W-1:0]        push_data;

  assign fifo_full  = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt_q == '0);
  assign start_go   = (state_q == IDLE) && start_i;
  assign accept     = score_valid_i && score_ready_o;
  assign last_class = (class_cnt_q == CLS_W'(NUM_CLASS - 1));
  assign last_img   = (img_cnt_q == IMG_W'(NUM_IMG - 1));

  // Argmax including the score being accepted this cycle; ties keep the lower index.
  always_comb begin
    max_d = max_q;
    idx_d = idx_q;
    if (class_cnt_q == '0) begin
      max_d = $signed(score_data_i);
      idx_d = '0;
    end else if ($signed(score_data_i) > max_q) begin
      max_d = $signed(score_data_i);
      idx_d = class_cnt_q;
    end
  end

  assign push      = accept && (!mode_q || last_class);
  assign push_data = mode_q ? DATA_W'(idx_d) : score_data_i;
  assign pop       = (state_q != IDLE) && !fifo_empty && !y_buf_stall_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // DRAIN waits for the last popped word to leave the output register as well.
  always_comb begin
    state_d       = state_q;
    score_ready_o = 1'b0;
    done_intr_o   = 1'b0;
    case (state_q)
      IDLE:  if (start_i) state_d = RUN;
      RUN: begin
        score_ready_o = !fifo_full;
        if (accept && last_class && last_img) state_d = DRAIN;
      end
      DRAIN: if (fifo_empty && !strobe_q) state_d = DONE;
      DONE: begin
        done_intr_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      class_cnt_q  <= '0;
      img_cnt_q    <= '0;
      mode_q       <= 1'b0;
      wr_addr_q    <= '0;
      max_q        <= '0;
      idx_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      strobe_q     <= 1'b0;
      y_buf_addr_o <= '0;
      y_buf_data_o <= '0;
      pred_valid_o <= 1'b0;
      pred_img_o   <= '0;
      pred_class_o <= '0;
      done_led_q   <= 1'b0;
    end else begin
      strobe_q     <= pop;
      pred_valid_o <= accept && last_class;

      if (start_go) begin
        class_cnt_q <= '0;
        img_cnt_q   <= '0;
        mode_q      <= mode_i;
        wr_addr_q   <= base_addr_i;
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        fifo_cnt_q  <= '0;
        done_led_q  <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop) begin
          rd_ptr_q     <= rd_ptr_q + PTR_W'(1);
          y_buf_addr_o <= wr_addr_q;
          y_buf_data_o <= fifo_mem[rd_ptr_q];
          wr_addr_q    <= wr_addr_q + ADDR_W'(BYTES_PER_WORD);
        end
        case ({push, pop})
          2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
          2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
          default: fifo_cnt_q <= fifo_cnt_q;
        endcase
        if (state_d == DONE) done_led_q <= 1'b1;
      end

      if (accept) begin
        max_q <= max_d;
        idx_q <= idx_d;
        if (last_class) begin
          class_cnt_q  <= '0;
          img_cnt_q    <= last_img ? '0 : img_cnt_q + IMG_W'(1);
          pred_img_o   <= img_cnt_q;
          pred_class_o <= idx_d;
        end else begin
          class_cnt_q <= class_cnt_q + CLS_W'(1);
        end
      end
    end
  end

  assign y_buf_en_o    = strobe_q;
  assign y_buf_wr_en_o = strobe_q;
  assign done_led_o    = done_led_q;

endmodule

// File: tb/tb_mlp_result_writer.sv
// Bench for mlp_result_writer: directed argmax table, stall/reset sequences and
// randomized runs checked against an argmax/address model built from the score stream.
module tb_mlp_result_writer;

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic        mode_i;
  logic [31:0] base_addr_i;
  logic        score_valid_i;
  logic        score_ready_o;
  logic [31:0] score_data_i;
  logic        y_buf_stall_i;
  logic        y_buf_en_o;
  logic        y_buf_wr_en_o;
  logic [31:0] y_buf_addr_o;
  logic [31:0] y_buf_data_o;
  logic        pred_valid_o;
  logic [3:0]  pred_img_o;
  logic [3:0]  pred_class_o;
  logic        done_intr_o;
  logic        done_led_o;

  mlp_result_writer #(
    .NUM_IMG(10), .NUM_CLASS(10), .DATA_W(32), .ADDR_W(32),
    .BYTES_PER_WORD(4), .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
    .base_addr_i(base_addr_i), .score_valid_i(score_valid_i),
    .score_ready_o(score_ready_o), .score_data_i(score_data_i),
    .y_buf_stall_i(y_buf_stall_i), .y_buf_en_o(y_buf_en_o),
    .y_buf_wr_en_o(y_buf_wr_en_o), .y_buf_addr_o(y_buf_addr_o),
    .y_buf_data_o(y_buf_data_o), .pred_valid_o(pred_valid_o),
    .pred_img_o(pred_img_o), .pred_class_o(pred_class_o),
    .done_intr_o(done_intr_o), .done_led_o(done_led_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- stimulus / model state ----------------
  logic [31:0] stim [100];
  logic [31:0] exp_addr [$];
  logic [31:0] exp_data [$];
  int          exp_cls [10];
  bit          cur_mode;

  typedef struct {
    logic [9:0][31:0] s;
    int               exp_cls;
  } vec_t;
  vec_t tbl [10];

  // ---------------- monitor ----------------
  logic [31:0] wq_addr [$];
  logic [31:0] wq_data [$];
  int          pq_img [$];
  int          pq_cls [$];
  int ncyc = 0, acc_cnt = 0, first_acc = -1, first_str = -1, last_str = -1;
  int done_cnt = 0, done_cyc = -1;

  initial forever begin
    @(negedge clk);
    ncyc++;
    if (y_buf_en_o || y_buf_wr_en_o) chk("en_eq_wr_en", y_buf_wr_en_o, y_buf_en_o);
    if (score_valid_i && score_ready_o) begin
      acc_cnt++;
      if (first_acc < 0) first_acc = ncyc;
    end
    if (y_buf_en_o) begin
      wq_addr.push_back(y_buf_addr_o);
      wq_data.push_back(y_buf_data_o);
      if (first_str < 0) first_str = ncyc;
      last_str = ncyc;
    end
    if (pred_valid_o) begin
      pq_img.push_back(int'(pred_img_o));
      pq_cls.push_back(int'(pred_class_o));
    end
    if (done_intr_o) begin
      done_cnt++;
      done_cyc = ncyc;
    end
  end

  int stall_mode = 0;
  initial forever begin
    @(posedge clk); #1;
    case (stall_mode)
      0:       y_buf_stall_i = 1'b0;
      1:       y_buf_stall_i = ($urandom_range(0, 3) == 0);
      default: y_buf_stall_i = 1'b1;
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic clear_mon();
    wq_addr.delete(); wq_data.delete(); pq_img.delete(); pq_cls.delete();
    acc_cnt = 0; first_acc = -1; first_str = -1; last_str = -1;
    done_cnt = 0; done_cyc = -1;
  endtask

  // Expected results straight from the rules: argmax per image, contiguous addresses.
  task automatic build_model(input bit mode, input logic [31:0] base);
    exp_addr.delete(); exp_data.delete();
    for (int img = 0; img < 10; img++) begin
      int best = 0;
      for (int c = 1; c < 10; c++)
        if ($signed(stim[img*10+c]) > $signed(stim[img*10+best])) best = c;
      exp_cls[img] = best;
    end
    if (mode == 1'b0) begin
      for (int j = 0; j < 100; j++) begin
        exp_addr.push_back(base + 32'(j * 4));
        exp_data.push_back(stim[j]);
      end
    end else begin
      for (int j = 0; j < 10; j++) begin
        exp_addr.push_back(base + 32'(j * 4));
        exp_data.push_back(32'(exp_cls[j]));
      end
    end
  endtask

  task automatic start_run(input bit mode, input logic [31:0] base);
    cur_mode = mode;
    build_model(mode, base);
    clear_mon();
    mode_i = mode; base_addr_i = base; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    mode_i = ~mode;
    base_addr_i = $urandom;
    chk("led_cleared_on_start", done_led_o, 0);
  endtask

  task automatic drive(input int n, input bit rnd);
    int i = 0;
    int guard = 0;
    bit v, r;
    while (i < n && guard < 20000) begin
      v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      score_valid_i = v;
      score_data_i  = stim[i];
      r = score_ready_o;
      @(posedge clk); #1;
      if (v && r) i++;
      guard++;
    end
    score_valid_i = 1'b0;
    chk("drive_complete", i, n);
  endtask

  task automatic check_run(input string tag);
    int guard = 0;
    while (done_cnt == 0 && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    chk({tag, "_done_seen"}, done_cnt != 0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_done_led"}, done_led_o, 1);
    chk({tag, "_done_after_last_strobe"}, done_cyc > last_str, 1);
    chk({tag, "_write_count"}, wq_addr.size(), exp_addr.size());
    for (int j = 0; j < exp_addr.size() && j < wq_addr.size(); j++) begin
      chk($sformatf("%s_addr[%0d]", tag, j), wq_addr[j], exp_addr[j]);
      chk($sformatf("%s_data[%0d]", tag, j), wq_data[j], exp_data[j]);
    end
    chk({tag, "_pred_count"}, pq_img.size(), 10);
    for (int j = 0; j < 10 && j < pq_img.size(); j++) begin
      chk($sformatf("%s_pred_img[%0d]", tag, j), pq_img[j], j);
      chk($sformatf("%s_pred_cls[%0d]", tag, j), pq_cls[j], exp_cls[j]);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, score_ready_o, 0);
    chk({tag, "_en"}, y_buf_en_o, 0);
    chk({tag, "_wr_en"}, y_buf_wr_en_o, 0);
    chk({tag, "_addr"}, y_buf_addr_o, 0);
    chk({tag, "_data"}, y_buf_data_o, 0);
    chk({tag, "_pred_valid"}, pred_valid_o, 0);
    chk({tag, "_pred_img"}, pred_img_o, 0);
    chk({tag, "_pred_class"}, pred_class_o, 0);
    chk({tag, "_done_intr"}, done_intr_o, 0);
    chk({tag, "_done_led"}, done_led_o, 0);
  endtask

  task automatic rand_stim();
    for (int k = 0; k < 100; k++) begin
      case ($urandom_range(0, 7))
        0:       stim[k] = 32'h7FFF_FFFF;
        1:       stim[k] = 32'h8000_0000;
        2:       stim[k] = 32'($urandom_range(0, 3));
        default: stim[k] = $urandom;
      endcase
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_i = 1'b1; start_i = 1'b0; mode_i = 1'b0; base_addr_i = '0;
    score_valid_i = 1'b0; score_data_i = '0; y_buf_stall_i = 1'b0;

    // Argmax vector table: ten images with hand-derived winning class.
    for (int t = 0; t < 10; t++) begin
      for (int c = 0; c < 10; c++) begin
        case (t)
          0: tbl[t].s[c] = 32'(c * 3);
          1: tbl[t].s[c] = 32'(c);
          2: tbl[t].s[c] = 32'(c - 20);
          3: tbl[t].s[c] = 32'd5;
          4: tbl[t].s[c] = 32'h8000_0000;
          5: tbl[t].s[c] = 32'(100 - c);
          6: tbl[t].s[c] = 32'(c * 7 - 50);
          7: tbl[t].s[c] = 32'hFFFF_FFFF;
          8: tbl[t].s[c] = 32'(c);
          default: tbl[t].s[c] = 32'(-(c + 1) * 1000);
        endcase
      end
    end
    tbl[0].s[7] = 32'h7FFF_FFFF;                   tbl[0].exp_cls = 7;
    tbl[1].s[2] = 32'd50; tbl[1].s[5] = 32'd50;    tbl[1].exp_cls = 2;
    tbl[2].s[9] = 32'hFFFF_FFFF;                   tbl[2].exp_cls = 9;
    tbl[3].exp_cls = 0;
    tbl[4].s[4] = 32'h8000_0001;                   tbl[4].exp_cls = 4;
    tbl[5].exp_cls = 0;
    tbl[6].exp_cls = 9;
    tbl[7].s[3] = 32'd0;                           tbl[7].exp_cls = 3;
    tbl[8].s[1] = 32'h7FFF_FFFF; tbl[8].s[8] = 32'h7FFF_FFFF; tbl[8].exp_cls = 1;
    tbl[9].s[6] = 32'd100;                         tbl[9].exp_cls = 6;

    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_ready_low", score_ready_o, 0);

    // Mode 0, scores 0..99, continuous, no stall.
    for (int k = 0; k < 100; k++) stim[k] = 32'(k);
    stall_mode = 0;
    start_run(1'b0, 32'h0);
    drive(100, 1'b0);
    check_run("m0_seq");
    chk("m0_first_latency", first_str - first_acc, 2);
    chk("m0_throughput", last_str - first_str, 99);

    // Mode 1 on the argmax table, base 0x1000.
    for (int t = 0; t < 10; t++)
      for (int c = 0; c < 10; c++) stim[t*10+c] = tbl[t].s[c];
    start_run(1'b1, 32'h1000);
    drive(100, 1'b0);
    check_run("m1_tbl");
    for (int t = 0; t < 10; t++) begin
      if (t < pq_cls.size())
        chk($sformatf("tbl_pred_cls[%0d]", t), pq_cls[t], tbl[t].exp_cls);
      if (t < wq_data.size()) begin
        chk($sformatf("tbl_wdata[%0d]", t), wq_data[t], tbl[t].exp_cls);
        chk($sformatf("tbl_waddr[%0d]", t), wq_addr[t], 32'h1000 + 32'(t * 4));
      end
    end

    // Stall held high from start: FIFO fills to 4, then release.
    rand_stim();
    stall_mode = 2;
    y_buf_stall_i = 1'b1;
    start_run(1'b0, 32'h40);
    fork
      drive(100, 1'b0);
      begin
        repeat (19) @(posedge clk);
        #2;
        chk("stall_accepted", acc_cnt, 4);
        chk("stall_ready_low", score_ready_o, 0);
        chk("stall_no_strobe", wq_addr.size(), 0);
        stall_mode = 0;
      end
    join
    check_run("stall");

    // Reset after 37 scores, then restart at base 0x200.
    rand_stim();
    stall_mode = 1;
    start_run(1'b0, 32'h0000_0800);
    drive(37, 1'b1);
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("midrst");
    rst_i = 1'b0;
    clear_mon();
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_writes", wq_addr.size(), 0);
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_ready_low", score_ready_o, 0);
    rand_stim();
    start_run(1'b0, 32'h200);
    drive(100, 1'b1);
    check_run("restart");
    if (wq_addr.size() > 0) begin
      chk("restart_first_addr", wq_addr[0], 32'h200);
      chk("restart_first_data", wq_data[0], stim[0]);
    end

    // Randomized runs: mode, base (incl. wrap), stall and valid gaps.
    for (int r = 0; r < 6; r++) begin
      logic [31:0] base;
      bit mode;
      rand_stim();
      mode = 1'($urandom_range(0, 1));
      base = (r == 2) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      stall_mode = 1;
      start_run(mode, base);
      fork
        drive(100, 1'b1);
        begin
          // A start pulse mid-run must be ignored.
          repeat (30) @(posedge clk);
          #1;
          start_i = 1'b1;
          @(posedge clk); #1;
          start_i = 1'b0;
        end
      join
      check_run($sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mlp_result_writer.md
# mlp_result_writer

Parametrised result-side engine of the MNIST MLP. Accepts the stream of signed class scores from the MLP core, tracks the per-image argmax, buffers results in a small FIFO and writes them to the output BRAM with byte addressing from a programmable base. Mode selects full score dump or argmax-only. Signals completion via interrupt pulse and LED level. Sits between the MLP core and the y_buf port of the top level.

## Interface
- NUM_IMG, 10, images per run
- NUM_CLASS, 10, scores per image
- DATA_W, 32, score and y_buf data width
- ADDR_W, 32, y_buf byte-address width
- BYTES_PER_WORD, 4, address stride per written word
- FIFO_DEPTH, 4, result FIFO entries (power of two, ≥2)

Ports:
- clk_i  in  1  single clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  run start pulse, honoured only in IDLE
- mode_i  in  1  0 = write every score, 1 = write argmax class index only; latched at start
- base_addr_i  in  ADDR_W  byte base address, latched at start
- score_valid_i  in  1  score present
- score_ready_o  out  1  score accepted when valid & ready
- score_data_i  in  DATA_W  signed two's-complement score
- y_buf_stall_i  in  1  sink cannot take a write next cycle
- y_buf_en_o, y_buf_wr_en_o  out  1  write strobe (always equal)
- y_buf_addr_o  out  ADDR_W  byte address
- y_buf_data_o  out  DATA_W  write data
- pred_valid_o  out  1  one-cycle pulse per finished image
- pred_img_o  out  $clog2(NUM_IMG)  image index of last prediction
- pred_class_o  out  $clog2(NUM_CLASS)  argmax of last image
- done_intr_o  out  1  one-cycle completion pulse
- done_led_o  out  1  completion level

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: score_ready_o=0. start_i=1 → clear class/img/write counters and FIFO, latch mode_i and base_addr_i, clear done_led_o, go RUN. start_i outside IDLE ignored.
- RUN: score_ready_o = FIFO not full. Per accepted score: class_cnt++; class 0 loads tracker (max, idx=0); later classes replace only if score > max (signed, strict; ties keep lower index).
- Mode 0: every accepted score pushed to FIFO. Mode 1: at the last class of each image, zero-extended argmax index (including the current score's compare) pushed; other scores pushed nowhere.
- Last class of an image accepted: class_cnt→0, img_cnt++, pred_valid_o pulses next cycle with pred_img_o/pred_class_o updated (held until next update). Last class of last image → DRAIN.
- Write side (all states except IDLE): each edge, if FIFO non-empty and y_buf_stall_i=0, pop head into output registers, en/wr_en=1 next cycle, addr = base + wr_idx*BYTES_PER_WORD (mod 2^ADDR_W), wr_idx++; else en/wr_en=0, addr/data hold.
- DRAIN: FIFO empty and no pending strobe → DONE.
- DONE (one cycle): done_intr_o=1, done_led_o set; → IDLE. done_led_o held until next accepted start or reset.
- Total writes: NUM_IMG*NUM_CLASS (mode 0) or NUM_IMG (mode 1).

## Timing
- Reset: all outputs 0, state IDLE, FIFO empty, counters 0. Reset mid-run aborts with no further writes; no done pulse.
- Score accepted in cycle N with FIFO empty and stall low in N+1 → strobe in cycle N+2 with its address/data. Mode 1: argmax word same latency from last class.
- Sustained throughput 1 score/cycle while stall low.
- Stall high in cycle N → no strobe in N+1; FIFO fills, score_ready_o falls same cycle FIFO reaches full; no data loss, order preserved.
- Simultaneous push and pop on a full FIFO not possible (ready gated by full); push and pop in same cycle otherwise legal, count unchanged.
- pred_valid_o and done_intr_o exactly one cycle each; done_intr_o after final strobe cycle.

## Test plan
- Reset: hold rst_i 3 cycles mid-stream → all outputs 0, score_ready_o=0 until next start.
- Mode 0, base 0, scores = 0..99, valid continuous, stall low → 100 strobes, addr 0,4,…,396, data = 0..99, one done_intr_o, done_led_o=1.
- Argmax: image 0 max at class 7 (value 0x7FFFFFFF), image 1 equal maxima at classes 2 and 5, image 2 all negative with max −1 at class 9 → pred_class 7, 2, 9 with pred_img 0,1,2.
- Mode 1, base 0x1000 → exactly 10 strobes, addr 0x1000..0x1024 step 4, data = per-image argmax.
- Stall high 20 cycles from start, FIFO_DEPTH=4 → exactly 4 scores accepted, ready low, no strobes; release → remaining stream written in order, addresses contiguous.
- Reset after 37 scores, then restart base 0x200 → first strobe addr 0x200, data = first new score, 100 writes total.
